ckt_sweep_checker: RTL and testbench

- Sequential stimulus-and-response stage wrapped around the 3-input gate-level circuit X = (A&B) | (~B&C).
- Drives a, b, c through all 8 input combinations, waits a settle window so gate delays can resolve, then samples x.
- Compares x against a golden model, counts mismatches and reports pass/fail.
- Replaces the hand-written, commented-out delay list with a synthesizable, self-checking sweep.

---
 rtl/ckt_sweep_pkg.sv | 18 +
 rtl/ckt_sweep_ctrl.sv | 82 ++++++++
 rtl/ckt_sweep_checker.sv | 113 +++++++++++
 tb/tb_ckt_sweep_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ckt_sweep_pkg.sv
// Shared types, constants and the golden model for the ckt sweep checker.
package ckt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam logic [2:0] VEC_LAST = 3'd7;

  // Reference behaviour of X = (A&B) | (~B&C) for vec = {a,b,c}.
  function automatic logic ckt_golden_f(input logic [2:0] vec);
    return vec[1] ? vec[2] : vec[0];
  endfunction

endpackage

// File: rtl/ckt_sweep_ctrl.sv
// Sweep sequencer: walks the 3-bit vector counter through 0..7, holding each
// vector for SETTLE_CYCLES+2 cycles (SETTLE phase plus one SAMPLE cycle).
// State is exposed on state_o so checkers can bind to it directly.
module ckt_sweep_ctrl
  import ckt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop_req,   // early termination request from the compare logic
  output sweep_state_t state_o,
  output logic [2:0]   vec_o,
  output logic         launch_o,   // start accepted this cycle
  output logic         sample_o,   // x is being compared this cycle
  output logic         finish_o    // this SAMPLE is the last of the sweep
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);

  sweep_state_t     state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers, cleared asynchronously so a reset aborts a sweep at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; start is only honoured when no sweep is running.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    launch_o = 1'b0;
    sample_o = 1'b0;
    finish_o = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          launch_o = 1'b1;
          vec_d    = 3'd0;
          cnt_d    = SETTLE_CNT;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        sample_o = 1'b1;
        if ((vec_q == VEC_LAST) || stop_req) begin
          finish_o = 1'b1;
          state_d  = DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = SETTLE_CNT;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
  assign vec_o   = vec_q;

endmodule

// File: rtl/ckt_sweep_checker.sv
// Self-checking exhaustive sweep around X = (A&B) | (~B&C).
// Drives {a,b,c} from a registered vector counter, samples x after a settle
// window and accumulates mismatches against the golden model.
// Optional macro CKT_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch,
// leaving the failing vector on a,b,c.
module ckt_sweep_checker
  import ckt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_vec
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  sweep_state_t state;
  logic [2:0]   vec;
  logic         launch;
  logic         sample;
  logic         finish;
  logic         stop_req;
  logic         mismatch;

  logic [ERR_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [2:0]       ffvec_q, ffvec_d;
  logic             pass_q, pass_d;

  assign mismatch = sample && (x != ckt_golden_f(vec));

`ifdef CKT_SWEEP_STOP_ON_FAIL_EN
  assign stop_req = mismatch;
`else
  assign stop_req = 1'b0;
`endif

  ckt_sweep_ctrl #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop_req (stop_req),
    .state_o  (state),
    .vec_o    (vec),
    .launch_o (launch),
    .sample_o (sample),
    .finish_o (finish)
  );

  // Result registers; async clear keeps every output at zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      pass_q  <= pass_d;
    end
  end

  // Compare/accumulate: clear on launch, count mismatches, latch the first failing vector.
  always_comb begin
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    pass_d  = pass_q;
    if (launch) begin
      err_d   = '0;
      ffv_d   = 1'b0;
      ffvec_d = 3'd0;
      pass_d  = 1'b0;
    end else if (sample) begin
      if (mismatch) begin
        err_d = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec;
        end
      end
      // pass reflects the final count, so a mismatch on the last vector counts.
      if (finish) begin
        pass_d = (err_d == '0);
      end
    end
  end

  assign {a, b, c}        = vec;
  assign busy             = (state == SETTLE) || (state == SAMPLE);
  assign done             = (state == DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_ckt_sweep_checker.sv
// Bench for ckt_sweep_checker: a delayed gate model of the circuit (or a tied
// value) feeds x; directed sweeps push expected results, a monitor pops them
// when done rises.
module tb_ckt_sweep_checker;

  localparam int W     = 20;
  localparam int ERR_W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT (SETTLE_CYCLES = 2)
  logic             start = 1'b0;
  logic             a, b, c, x, busy, done, pass, ffv;
  logic [ERR_W-1:0] err;
  logic [2:0]       ffvec;
  logic [1:0]       x_sel = 2'd0;   // 0: real circuit, 1: tied 0, 2: tied 1

  // DUT (SETTLE_CYCLES = 0)
  logic             start_z = 1'b0;
  logic             a_z, b_z, c_z, x_z, busy_z, done_z, pass_z, ffv_z;
  logic [ERR_W-1:0] err_z;
  logic [2:0]       ffvec_z;

  // gate-level circuit with 1-unit gate delays (worst path 3 units)
  logic nb, t1, t2, x_ckt;
  assign #1 nb    = ~b;
  assign #1 t1    = a & b;
  assign #1 t2    = nb & c;
  assign #1 x_ckt = t1 | t2;
  assign x = (x_sel == 2'd0) ? x_ckt : (x_sel == 2'd1) ? 1'b0 : 1'b1;

  logic nb_z, t1_z, t2_z;
  assign #1 nb_z = ~b_z;
  assign #1 t1_z = a_z & b_z;
  assign #1 t2_z = nb_z & c_z;
  assign #1 x_z  = t1_z | t2_z;

  ckt_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .x(x),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  ckt_sweep_checker #(.SETTLE_CYCLES(0), .ERR_W(ERR_W)) dut_z (
    .clk(clk), .rst(rst), .start(start_z), .a(a_z), .b(b_z), .c(c_z), .x(x_z),
    .busy(busy_z), .done(done_z), .pass(pass_z), .err_count(err_z),
    .first_fail_valid(ffv_z), .first_fail_vec(ffvec_z)
  );

  // scoreboard
  // packed: [19:12] latency, [11] pass, [10:7] err_count, [6] ffv, [5:3] ffvec, [2:0] {a,b,c}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_z_q[$];
  int unsigned  start_cyc   = 0;
  int unsigned  start_cyc_z = 0;
  int checks   = 0;
  int failures = 0;

  function automatic logic [W-1:0] pack(input int lat, input logic p, input logic [3:0] e,
                                        input logic v, input logic [2:0] fv, input logic [2:0] abc);
    logic [7:0] l;
    l = lat[7:0];
    return {l, p, e, v, fv, abc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: on each rising edge of done, pop and compare the expected result
  logic         done_prev   = 1'b0;
  logic         done_z_prev = 1'b0;
  logic [W-1:0] e_m;
  logic [7:0]   lat_m;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        e_m   = exp_q.pop_front();
        lat_m = 8'(cyc - start_cyc);
        check("latency",          32'(lat_m),         32'(e_m[19:12]));
        check("pass",             32'(pass),          32'(e_m[11]));
        check("err_count",        32'(err),           32'(e_m[10:7]));
        check("first_fail_valid", 32'(ffv),           32'(e_m[6]));
        check("first_fail_vec",   32'(ffvec),         32'(e_m[5:3]));
        check("abc_in_done",      32'({a, b, c}),     32'(e_m[2:0]));
        check("busy_in_done",     32'(busy),          32'(0));
      end
    end
    if (done_z && !done_z_prev) begin
      if (exp_z_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done_z actual=1 required=0 (t=%0t)", $time);
      end else begin
        e_m   = exp_z_q.pop_front();
        lat_m = 8'(cyc - start_cyc_z);
        check("z_latency",   32'(lat_m),           32'(e_m[19:12]));
        check("z_pass",      32'(pass_z),          32'(e_m[11]));
        check("z_err_count", 32'(err_z),           32'(e_m[10:7]));
        check("z_ffv",       32'(ffv_z),           32'(e_m[6]));
        check("z_abc",       32'({a_z, b_z, c_z}), 32'(e_m[2:0]));
      end
    end
    done_prev   = done;
    done_z_prev = done_z;
  end

  // driver tasks
  task automatic do_start(input bit push, input logic [W-1:0] e);
    @(negedge clk);
    if (push) exp_q.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic do_start_z(input logic [W-1:0] e);
    @(negedge clk);
    exp_z_q.push_back(e);
    start_z = 1'b1;
    @(posedge clk);
    #1;
    start_cyc_z = cyc;
    start_z     = 1'b0;
  endtask

  task automatic wait_done(input bit z, input int max);
    int n;
    n = 0;
    while (!(z ? done_z : done) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!(z ? done_z : done)) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=0 required=1 (t=%0t)", $time);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abc"},   32'({a, b, c}), 32'(0));
    check({tag, "_busy"},  32'(busy),      32'(0));
    check({tag, "_done"},  32'(done),      32'(0));
    check({tag, "_pass"},  32'(pass),      32'(0));
    check({tag, "_err"},   32'(err),       32'(0));
    check({tag, "_ffv"},   32'(ffv),       32'(0));
    check({tag, "_ffvec"}, 32'(ffvec),     32'(0));
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    logic [W-1:0] e0, e1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_z_busy", 32'(busy_z), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // real circuit: full sweep passes, done 32 cycles after start
    x_sel = 2'd0;
    do_start(1'b1, pack(32, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7));
    wait_done(1'b0, 60);

    // x tied 0: expect 1 on 001,101,110,111
`ifdef CKT_SWEEP_STOP_ON_FAIL_EN
    e0 = pack(8, 1'b0, 4'd1, 1'b1, 3'b001, 3'b001);
    e1 = pack(4, 1'b0, 4'd1, 1'b1, 3'b000, 3'b000);
`else
    e0 = pack(32, 1'b0, 4'd4, 1'b1, 3'b001, 3'd7);
    e1 = pack(32, 1'b0, 4'd4, 1'b1, 3'b000, 3'd7);
`endif
    x_sel = 2'd1;
    do_start(1'b1, e0);
    // start in DONE clears results on the next cycle
    check("restart_done_cleared", 32'(done), 32'(0));
    check("restart_busy",         32'(busy), 32'(1));
    check("restart_pass_cleared", 32'(pass), 32'(0));
    wait_done(1'b0, 60);
    check("done_hold_err", 32'(err), 32'(e0[10:7]));
    do_start(1'b1, e1);
    check("restart_err_cleared", 32'(err), 32'(0));
    check("restart_ffv_cleared", 32'(ffv), 32'(0));
    x_sel = 2'd2;
    wait_done(1'b0, 60);

    // reset at cycle 13 of a sweep aborts immediately
    x_sel = 2'd0;
    do_start(1'b0, '0);
    repeat (13) @(posedge clk);
    #2;
    check("mid_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_start(1'b1, pack(32, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7));
    wait_done(1'b0, 60);

    // start held high then re-pulsed while busy: no restart
    @(negedge clk);
    exp_q.push_back(pack(32, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7));
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    repeat (20) @(posedge clk);
    #1;
    check("held_start_vec", 32'({a, b, c}), 32'(5));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 60);

    // zero settle window: done after 16 cycles
    do_start_z(pack(16, 1'b1, 4'd0, 1'b0, 3'd0, 3'd7));
    wait_done(1'b1, 40);

    repeat (2) @(negedge clk);
    check("exp_q_drained",   32'(exp_q.size()),   32'(0));
    check("exp_z_q_drained", 32'(exp_z_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
